butterfly_engine_job_scheduler: RTL and testbench
=================================================

// Module: butterfly_engine_job_scheduler
// PURPOSE
//  Sequences jobs onto butterfly_engine_opt_top. Pops one command at a time and drives the engine
//  mode/config pins (is_fft, is_ln, is_sc_cache, is_sc_add, length, is_bypass_p2s), holding them
//  stable for the whole job. Gates the input stream and the coefficient load, then counts output
//  beats to detect job completion. Sits between the host command queue and the engine.
// PARAMETERS
//  LEN_W       16  width of length / beat counters
//  CFG_SETTLE  2   cycles the config is held before streaming (covers engine is_sc_*_r retiming)
//  TO_W        20  watchdog counter width; timeout when counter saturates at 2^TO_W-1
// PORTS
//  clk              in   1        clock
//  rst_n            in   1        async active-low reset
//  cmd_vld          in   1        command valid
//  cmd_rdy          out  1        command accepted when cmd_vld&cmd_rdy
//  cmd_op           in   3        0 FFT, 1 BFLY, 2 LN, 3 SC_CACHE, 4 SC_ADD; 5-7 illegal
//  cmd_len          in   LEN_W    engine length
//  cmd_bypass       in   1        is_bypass_p2s for the job
//  cmd_in_beats     in   LEN_W    input beats to forward (0 = none)
//  cmd_out_beats    in   LEN_W    output beats expected
//  cmd_coef_beats   in   LEN_W    coefficient beats to forward (0 = skip LOAD)
//  abort            in   1        synchronous abort of current job
//  src_vld/src_rdy  in/out 1      input stream handshake from upstream
//  eng_up_vld       out  1        to engine up_vld
//  eng_up_rdy       in   1        from engine up_rdy
//  coef_src_vld     in   1        coefficient beat available
//  coef_src_rdy     out  1        coefficient beat taken
//  eng_coef_vld     out  1        to engine butterfly_coef_vld
//  eng_out_vld      in   1        lane-0 output valid (serial_A or parallel_A per bypass, muxed outside)
//  eng_is_fft, eng_is_ln, eng_is_sc_cache, eng_is_sc_add  out 1 each  engine mode
//  eng_length       out  LEN_W    engine length
//  eng_bypass_p2s   out  1        engine is_bypass_p2s
//  busy             out  1        state != IDLE
//  job_done         out  1        1-cycle pulse on normal completion
//  job_err          out  2        sticky until next accept: [0] illegal op, [1] timeout
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (cmd_rdy 0 in reset, 1 in IDLE next cycle); counters 0.
//  FSM: IDLE -> CFG -> LOAD -> STREAM -> DRAIN -> DONE -> IDLE.
//   IDLE: cmd_rdy=1. On accept latch fields; illegal op -> job_err[0]=1, job_done pulse, stay IDLE.
//   CFG: mode regs driven from latched op (SC_CACHE sets is_sc_cache only, SC_ADD is_sc_add only,
//    BFLY all mode bits 0); wait CFG_SETTLE cycles. Next LOAD if coef_beats!=0, else STREAM.
//   LOAD: coef_src_rdy=1, eng_coef_vld=coef_src_vld; count beats; at count==coef_beats -> STREAM.
//   STREAM: eng_up_vld=src_vld&(in_cnt<in_beats); src_rdy=eng_up_rdy&(in_cnt<in_beats) (comb,
//    zero latency); in_cnt++ on src_vld&src_rdy. in_cnt==in_beats -> DRAIN.
//   Output count: out_cnt++ on eng_out_vld in STREAM and DRAIN (outputs may overlap input).
//   DRAIN: out_cnt==out_beats -> DONE. Extra eng_out_vld beyond out_beats ignored (no wrap).
//   DONE: job_done=1 one cycle; mode regs cleared to 0; -> IDLE.
//  Mode/length/bypass outputs are registered and constant from CFG entry until DONE.
//  Watchdog: counts cycles without any handshake in LOAD/STREAM/DRAIN; resets on any beat; at
//   saturation set job_err[1], -> IDLE without job_done, mode regs cleared.
//  abort: from any non-IDLE state -> IDLE next cycle, counters cleared, no job_done; wins over
//   completion in the same cycle. abort in IDLE ignored.
//  Counters LEN_W wide, compare with ==; out_beats=0 makes DRAIN exit immediately.
//  Async reset mid-job: immediate return to reset values; engine pins drop to 0.
// STRUCTURE
//  Package butterfly_sched_pkg: op encodings, state encoding, error bit indices.
//  One sub-module: bfly_sched_beat_counter (load/enable/clear counter with ==target flag),
//  instantiated for coef, in, out beats. Watchdog and FSM inline.
// TESTING
//  FFT op, len=64, coef=0, in=16, out=16, src always vld -> eng_is_fft=1 after CFG, 16 up beats, job_done once.
//  BFLY coef=4, in=8 with eng_up_rdy toggling 1/0 -> exactly 4 coef beats then 8 up beats, no loss.
//  SC_ADD out=8 with engine outputs overlapping STREAM -> DRAIN exits on 8th beat, is_sc_add=1 through job.
//  op=6 -> job_err=2'b01, job_done pulse, FSM stays IDLE, engine pins 0.
//  TO_W=6, out=4 but only 2 out beats -> job_err[1] after 63 idle cycles, busy=0, no job_done.
//  abort in STREAM after 3 beats, then new LN job -> counters restart at 0, eng_is_ln=1.

Source files
------------

// File: rtl/butterfly_sched_pkg.sv
// butterfly_sched_pkg: shared encodings for the butterfly engine job scheduler
//  op_e      command opcodes (5-7 are illegal)
//  state_e   scheduler FSM states
//  ERR_*     bit positions inside job_err
package butterfly_sched_pkg;
    typedef enum logic [2:0] {
        OP_FFT      = 3'd0,
        OP_BFLY     = 3'd1,
        OP_LN       = 3'd2,
        OP_SC_CACHE = 3'd3,
        OP_SC_ADD   = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CFG    = 3'd1,
        S_LOAD   = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    localparam int ERR_ILLEGAL = 0;
    localparam int ERR_TIMEOUT = 1;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_SC_ADD;
    endfunction
endpackage

// File: rtl/bfly_sched_beat_counter.sv
// bfly_sched_beat_counter: beat counter with latched target and ==target flag
//  clk, rst_n   clock, async active-low reset
//  ld           latch tgt and restart count at 0
//  clr          restart count at 0, keep target
//  en           count one beat (ignored once the target is reached, so it never wraps)
//  tgt          target beat count
//  hit          count == target
module bfly_sched_beat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tgt,
    output logic         hit
);
    logic [W-1:0] cnt;
    logic [W-1:0] tgt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            tgt_q <= '0;
        end else if (ld) begin
            cnt   <= '0;
            tgt_q <= tgt;
        end else if (clr) begin
            cnt   <= '0;
        end else if (en && !hit) begin
            cnt   <= cnt + 1'b1;
        end
    end

    assign hit = cnt == tgt_q;
endmodule

// File: rtl/butterfly_engine_job_scheduler.sv
// butterfly_engine_job_scheduler: sequences host commands onto butterfly_engine_opt_top
//  cmd_*                 command handshake and fields (op, length, bypass, beat counts)
//  abort                 drop the current job, back to IDLE without job_done
//  src_vld/src_rdy       upstream input stream, forwarded as eng_up_vld / eng_up_rdy
//  coef_src_vld/rdy      coefficient source, forwarded as eng_coef_vld
//  eng_out_vld           engine lane-0 output beat, counted for completion
//  eng_is_*, eng_length, eng_bypass_p2s   registered engine mode pins, held for the job
//  busy, job_done, job_err                status (job_err[0] illegal op, [1] watchdog timeout)
module butterfly_engine_job_scheduler
    import butterfly_sched_pkg::*;
#(
    parameter int LEN_W      = 16,
    parameter int CFG_SETTLE = 2,
    parameter int TO_W       = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_vld,
    output logic             cmd_rdy,
    input  logic [2:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_bypass,
    input  logic [LEN_W-1:0] cmd_in_beats,
    input  logic [LEN_W-1:0] cmd_out_beats,
    input  logic [LEN_W-1:0] cmd_coef_beats,
    input  logic             abort,
    input  logic             src_vld,
    output logic             src_rdy,
    output logic             eng_up_vld,
    input  logic             eng_up_rdy,
    input  logic             coef_src_vld,
    output logic             coef_src_rdy,
    output logic             eng_coef_vld,
    input  logic             eng_out_vld,
    output logic             eng_is_fft,
    output logic             eng_is_ln,
    output logic             eng_is_sc_cache,
    output logic             eng_is_sc_add,
    output logic [LEN_W-1:0] eng_length,
    output logic             eng_bypass_p2s,
    output logic             busy,
    output logic             job_done,
    output logic [1:0]       job_err
);
    state_e          state, state_nx;
    logic            live_q;
    logic            err_done_q;
    logic [7:0]      settle_q;
    logic [TO_W-1:0] wd_q;
    logic            accept, legal, active, in_hs, out_en, hs, timeout, kill;
    logic            coef_hit, in_hit, out_hit;

    // live_q keeps cmd_rdy low while in reset and for the first edge after it
    assign cmd_rdy      = live_q && state == S_IDLE;
    assign accept       = cmd_vld && cmd_rdy;
    assign legal        = op_legal(cmd_op);
    assign active       = state inside {S_LOAD, S_STREAM, S_DRAIN};
    // rdy drops once the last coefficient beat is in, so no extra beat is taken
    assign coef_src_rdy = state == S_LOAD && !coef_hit;
    assign eng_coef_vld = coef_src_rdy && coef_src_vld;
    assign eng_up_vld   = state == S_STREAM && !in_hit && src_vld;
    assign src_rdy      = state == S_STREAM && !in_hit && eng_up_rdy;
    assign in_hs        = src_vld && src_rdy;
    assign out_en       = (state == S_STREAM || state == S_DRAIN) && eng_out_vld;
    assign hs           = eng_coef_vld || in_hs || out_en;
    assign timeout      = active && &wd_q;
    assign kill         = (abort && state != S_IDLE) || timeout;
    assign busy         = state != S_IDLE;
    assign job_done     = state == S_DONE || err_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept && legal) state_nx = S_CFG;
            S_CFG:    if (settle_q == 8'(CFG_SETTLE - 1)) state_nx = coef_hit ? S_STREAM : S_LOAD;
            S_LOAD:   if (coef_hit) state_nx = S_STREAM;
            S_STREAM: if (in_hit) state_nx = S_DRAIN;
            S_DRAIN:  if (out_hit) state_nx = S_DONE;
            default:  state_nx = S_IDLE;
        endcase
        if (kill) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q          <= 1'b0;
            err_done_q      <= 1'b0;
            job_err         <= '0;
            settle_q        <= '0;
            wd_q            <= '0;
            eng_is_fft      <= 1'b0;
            eng_is_ln       <= 1'b0;
            eng_is_sc_cache <= 1'b0;
            eng_is_sc_add   <= 1'b0;
            eng_length      <= '0;
            eng_bypass_p2s  <= 1'b0;
        end else begin
            live_q     <= 1'b1;
            err_done_q <= accept && !legal;
            if (accept) begin
                job_err              <= '0;
                job_err[ERR_ILLEGAL] <= !legal;
            end else if (timeout) begin
                job_err[ERR_TIMEOUT] <= 1'b1;
            end
            settle_q <= state == S_CFG ? settle_q + 8'd1 : 8'd0;
            wd_q     <= active && !hs ? wd_q + 1'b1 : '0;
            if (accept && legal) begin
                eng_is_fft      <= cmd_op == OP_FFT;
                eng_is_ln       <= cmd_op == OP_LN;
                eng_is_sc_cache <= cmd_op == OP_SC_CACHE;
                eng_is_sc_add   <= cmd_op == OP_SC_ADD;
                eng_length      <= cmd_len;
                eng_bypass_p2s  <= cmd_bypass;
            end else if (kill || state == S_DONE) begin
                eng_is_fft      <= 1'b0;
                eng_is_ln       <= 1'b0;
                eng_is_sc_cache <= 1'b0;
                eng_is_sc_add   <= 1'b0;
                eng_length      <= '0;
                eng_bypass_p2s  <= 1'b0;
            end
        end
    end

    bfly_sched_beat_counter #(.W(LEN_W)) u_coef_cnt (
        .clk(clk), .rst_n(rst_n), .ld(accept && legal), .clr(kill),
        .en(eng_coef_vld), .tgt(cmd_coef_beats), .hit(coef_hit)
    );

    bfly_sched_beat_counter #(.W(LEN_W)) u_in_cnt (
        .clk(clk), .rst_n(rst_n), .ld(accept && legal), .clr(kill),
        .en(in_hs), .tgt(cmd_in_beats), .hit(in_hit)
    );

    bfly_sched_beat_counter #(.W(LEN_W)) u_out_cnt (
        .clk(clk), .rst_n(rst_n), .ld(accept && legal), .clr(kill),
        .en(out_en), .tgt(cmd_out_beats), .hit(out_hit)
    );
endmodule

// File: tb/tb_butterfly_engine_job_scheduler.sv
// tb_butterfly_engine_job_scheduler: scoreboard bench for the butterfly engine job scheduler
module tb_butterfly_engine_job_scheduler;
    typedef enum {K_NORMAL, K_ILLEGAL, K_TIMEOUT, K_ABORT, K_RST} kind_e;
    typedef struct {
        logic [2:0]  op;
        logic [15:0] len;
        logic        byp;
        int          coef;
        int          inb;
        kind_e       kind;
    } job_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_vld = 1'b0, cmd_bypass = 1'b0, abort = 1'b0;
    logic [2:0]  cmd_op = '0;
    logic [15:0] cmd_len = '0, cmd_in_beats = '0, cmd_out_beats = '0, cmd_coef_beats = '0;
    logic        cmd_rdy, src_vld, src_rdy, eng_up_vld, eng_up_rdy, coef_src_vld, coef_src_rdy;
    logic        eng_coef_vld, eng_out_vld, eng_is_fft, eng_is_ln, eng_is_sc_cache, eng_is_sc_add;
    logic        eng_bypass_p2s, busy, job_done;
    logic [15:0] eng_length;
    logic [1:0]  job_err;

    job_t exp_q[$];
    int   n_tests = 0, n_fail = 0;
    int   u_cnt = 0, s_cnt = 0, c_cnt = 0, d_cnt = 0, idle_run = 0, ends = 0;
    int   out_left = 0;
    logic busy_prev = 1'b0, free_out = 1'b0, hold_abort = 1'b0, src_all = 1'b0, rdy_toggle = 1'b0;

    butterfly_engine_job_scheduler #(.LEN_W(16), .CFG_SETTLE(2), .TO_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_bypass(cmd_bypass), .cmd_in_beats(cmd_in_beats),
        .cmd_out_beats(cmd_out_beats), .cmd_coef_beats(cmd_coef_beats), .abort(abort),
        .src_vld(src_vld), .src_rdy(src_rdy), .eng_up_vld(eng_up_vld), .eng_up_rdy(eng_up_rdy),
        .coef_src_vld(coef_src_vld), .coef_src_rdy(coef_src_rdy), .eng_coef_vld(eng_coef_vld),
        .eng_out_vld(eng_out_vld), .eng_is_fft(eng_is_fft), .eng_is_ln(eng_is_ln),
        .eng_is_sc_cache(eng_is_sc_cache), .eng_is_sc_add(eng_is_sc_add), .eng_length(eng_length),
        .eng_bypass_p2s(eng_bypass_p2s), .busy(busy), .job_done(job_done), .job_err(job_err)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] pins();
        return {eng_is_fft, eng_is_ln, eng_is_sc_cache, eng_is_sc_add, eng_bypass_p2s, eng_length};
    endfunction

    // Engine pins a job of this opcode must present: one mode bit per op, BFLY none
    function automatic logic [20:0] exp_pins(input job_t j);
        return {j.op == 3'd0, j.op == 3'd2, j.op == 3'd3, j.op == 3'd4, j.byp, j.len};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    // Upstream, coefficient source and engine output models
    initial begin
        logic tog;
        tog = 1'b0;
        src_vld = 1'b0; eng_up_rdy = 1'b0; coef_src_vld = 1'b0; eng_out_vld = 1'b0;
        forever begin
            @(posedge clk); #1;
            tog = ~tog;
            src_vld = src_all || ($urandom % 10 < 7);
            if (hold_abort && u_cnt >= 3) src_vld = 1'b0;
            eng_up_rdy = rdy_toggle ? tog : ($urandom % 10 < 6);
            coef_src_vld = $urandom % 10 < 6;
            if (!busy) eng_out_vld = 1'b0;
            else if (free_out) eng_out_vld = ($urandom % 2) == 1;
            else if (u_cnt > 0 && out_left > 0) begin
                eng_out_vld = ($urandom % 2) == 1;
                if (eng_out_vld) out_left--;
            end else eng_out_vld = 1'b0;
        end
    end

    // Monitor: counts beats per job, pops the expected job when the DUT ends one
    initial begin
        job_t e;
        logic bc, bu, bs;
        int   exp_up;
        forever begin
            @(negedge clk);
            bc = eng_coef_vld && coef_src_rdy;
            bu = eng_up_vld && eng_up_rdy;
            bs = src_vld && src_rdy;
            if (bc) c_cnt++;
            if (bu) u_cnt++;
            if (bs) s_cnt++;
            if (job_done) d_cnt++;
            if ((bc || bu) && exp_q.size() > 0) chk("pins_during_job", 32'(pins()), 32'(exp_pins(exp_q[0])));
            if ((busy_prev && !busy) || (job_done && !busy)) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_empty: job ended with nothing expected");
                end else begin
                    e = exp_q.pop_front();
                    exp_up = e.kind == K_ILLEGAL ? 0 : e.kind == K_ABORT ? 3 : e.inb;
                    chk("job_done_pulses", d_cnt, (e.kind == K_NORMAL || e.kind == K_ILLEGAL) ? 1 : 0);
                    chk("job_err", 32'(job_err), e.kind == K_ILLEGAL ? 1 : e.kind == K_TIMEOUT ? 2 : 0);
                    chk("pins_after_job", 32'(pins()), 0);
                    if (e.kind != K_RST) begin
                        chk("coef_beats", c_cnt, e.kind == K_ILLEGAL ? 0 : e.coef);
                        chk("up_beats", u_cnt, exp_up);
                        chk("src_beats", s_cnt, exp_up);
                    end
                    // 63 counted idle cycles to saturate plus the cycle that sees saturation
                    if (e.kind == K_TIMEOUT) chk("watchdog_idle_cycles", idle_run, 64);
                end
                c_cnt = 0; u_cnt = 0; s_cnt = 0; d_cnt = 0;
                ends++;
            end
            idle_run = (busy && !(bc || bu || eng_out_vld)) ? idle_run + 1 : 0;
            busy_prev = busy;
        end
    end

    task automatic run_job(input logic [2:0] op, input logic [15:0] len, input logic byp, input int coef,
                           input int inb, input int outb, input int outs, input kind_e kind);
        job_t j;
        int   k, e0;
        j.op = op; j.len = len; j.byp = byp; j.coef = coef; j.inb = inb; j.kind = kind;
        exp_q.push_back(j);
        out_left = outs;
        free_out = inb == 0;
        hold_abort = kind == K_ABORT;
        e0 = ends;
        @(posedge clk); #1;
        cmd_vld = 1'b1; cmd_op = op; cmd_len = len; cmd_bypass = byp;
        cmd_coef_beats = 16'(coef); cmd_in_beats = 16'(inb); cmd_out_beats = 16'(outb);
        k = 0;
        while (!cmd_rdy && k < 50) begin @(posedge clk); #1; k++; end
        if (!cmd_rdy) bound_fail("cmd_accept");
        @(posedge clk); #1;
        cmd_vld = 1'b0;
        if (kind == K_ABORT) begin
            k = 0;
            while (u_cnt < 3 && k < 500) begin @(posedge clk); #1; k++; end
            if (u_cnt < 3) bound_fail("abort_wait_beats");
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end
        if (kind == K_RST) begin
            k = 0;
            while (u_cnt < 2 && k < 500) begin @(posedge clk); #1; k++; end
            if (u_cnt < 2) bound_fail("reset_wait_beats");
            #2 rst_n = 1'b0;
            #1 chk("async_reset_outputs", 32'({busy, cmd_rdy, eng_up_vld, src_rdy, job_err, pins()}), 0);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
        end
        k = 0;
        while (ends == e0 && k < 4000) begin @(posedge clk); k++; end
        if (ends == e0) begin
            bound_fail("job_end");
            summary();
        end
        #1 hold_abort = 1'b0;
    endtask

    initial begin
        logic [2:0] op;
        int         inb, outb;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({cmd_rdy, src_rdy, eng_up_vld, coef_src_rdy, eng_coef_vld,
                                  busy, job_done, job_err, pins()}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", 32'({busy, cmd_rdy}), 1);

        src_all = 1'b1;
        run_job(3'd0, 16'd64, 1'b0, 0, 16, 16, 16, K_NORMAL);
        src_all = 1'b0;
        rdy_toggle = 1'b1;
        run_job(3'd1, 16'd32, 1'b1, 4, 8, 6, 6, K_NORMAL);
        rdy_toggle = 1'b0;
        run_job(3'd4, 16'd128, 1'b0, 2, 8, 8, 8, K_NORMAL);
        run_job(3'd6, 16'd99, 1'b1, 3, 4, 4, 4, K_ILLEGAL);
        #1 chk("illegal_stays_idle", 32'({busy, cmd_rdy, job_err}), 32'b1_01);
        run_job(3'd2, 16'd16, 1'b0, 1, 6, 4, 2, K_TIMEOUT);
        #1 chk("timeout_err_sticky", 32'({busy, job_err}), 2);
        run_job(3'd0, 16'd64, 1'b0, 0, 10, 4, 0, K_ABORT);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_in_idle_ignored", 32'({busy, cmd_rdy}), 1);
        run_job(3'd2, 16'd256, 1'b1, 0, 5, 5, 5, K_NORMAL);
        run_job(3'd3, 16'd8, 1'b0, 0, 0, 0, 0, K_NORMAL);
        run_job(3'd1, 16'd9, 1'b0, 2, 3, 0, 2, K_NORMAL);
        for (int n = 0; n < 30; n++) begin
            op = ($urandom % 8 == 0) ? 3'(5 + $urandom % 3) : 3'($urandom % 5);
            inb = int'($urandom % 11);
            outb = int'($urandom % 11);
            run_job(op, 16'($urandom), ($urandom % 2) == 1, int'($urandom % 6), inb, outb,
                    outb + int'($urandom % 3), op > 3'd4 ? K_ILLEGAL : K_NORMAL);
        end
        run_job(3'd0, 16'd64, 1'b0, 2, 10, 10, 10, K_RST);
        run_job(3'd4, 16'd77, 1'b1, 1, 3, 2, 2, K_NORMAL);
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        summary();
    end
endmodule
